serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..16.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release synchronous to clock.
REQ-004 A  input  WIDTH  minuend, sampled only on the accepted start edge.
REQ-005 B  input  WIDTH  subtrahend, sampled only on the accepted start edge.
REQ-006 start  input  1  request to begin one subtraction; level-sampled each rising edge.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse marking result valid.
REQ-009 diff  output  WIDTH  registered result A - B modulo 2^WIDTH.
REQ-010 borrow  output  1  registered final borrow; 1 when A < B unsigned.
REQ-011 ovf  output  1  signed overflow flag; present only under REQ-027.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE: start=1 at edge k SHALL load A and B into internal shift registers, clear the internal borrow, load the bit counter with WIDTH, and go to RUN; start=0 stays IDLE.
REQ-014 RUN: each edge SHALL process one bit LSB-first: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~a0 & bin) | (b0 & bin); d shifts into the MSB of the internal result register; operand registers shift right with 0 fill; counter decrements.
REQ-015 The edge processing the last bit (counter 1 -> 0) SHALL copy the completed result to diff, bout to borrow, go to DONE, and set done=1.
REQ-016 Latency: start accepted at edge k -> diff/borrow updated and done high from edge k+WIDTH to edge k+WIDTH+1.
REQ-017 DONE: the next edge SHALL clear done and go to IDLE unconditionally; start seen in DONE SHALL be ignored.
REQ-018 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored with no effect on the operation in flight; A and B changes after the accept edge SHALL not affect the result.
REQ-020 diff and borrow SHALL hold their values between completions and change only on the REQ-015 edge.
REQ-021 start held high continuously SHALL produce back-to-back operations, one every WIDTH+2 cycles.
REQ-022 A == B SHALL yield diff=0, borrow=0; A=0, B=2^WIDTH-1 SHALL yield diff=1, borrow=1.

Reset
REQ-023 reset low SHALL force state IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0 (if present), counter=0, internal registers 0, asynchronously.
REQ-024 reset asserted mid-RUN SHALL abort the operation with no done pulse; diff/borrow SHALL read 0.
REQ-025 The first edge after reset release with start=1 SHALL be accepted as a normal start.

Configuration
REQ-026 Macro SERIAL_SUB_OVF_EN selects the signed-overflow feature.
REQ-027 Defined: port ovf exists; on the REQ-015 edge ovf SHALL be set to (borrow into MSB stage) XOR (borrow out of MSB stage) and held like diff. Undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 WIDTH=8, A=8'h5A, B=8'h3C, start one cycle -> done at edge k+8, diff=8'h1E, borrow=0, busy high 9 cycles.
REQ-029 A=8'h00, B=8'h01 -> diff=8'hFF, borrow=1; with SERIAL_SUB_OVF_EN ovf=0.
REQ-030 OVF_EN: A=8'h80, B=8'h01 -> diff=8'h7F, borrow=0, ovf=1; A=8'h7F, B=8'hFF -> diff=8'h80, borrow=1, ovf=1.
REQ-031 start pulsed at k+3 during RUN and A/B changed at k+1 -> ignored, result equals the operands sampled at k, single done pulse.
REQ-032 reset low at edge k+4 of an operation -> busy=0, done never asserted, diff=0; a subsequent start of 8'hFF-8'hFF completes with diff=0, borrow=0.
REQ-033 start held high for 30 cycles -> done pulses every 10 cycles, each with correct diff for the A/B value present at its accept edge.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; ovf is present only with SERIAL_SUB_OVF_EN.
// The master drives operands and start, and the slave returns status and result.
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             start;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (output A, B, start, input busy, done, diff, borrow, ovf);
   modport slave  (input A, B, start, output busy, done, diff, borrow, ovf);
`else
   modport master (output A, B, start, input busy, done, diff, borrow);
   modport slave  (input A, B, start, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first: a start accepted at edge k gives done/diff at edge k+WIDTH.
// Starts are ignored while busy. The optional signed-overflow flag is enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] diff_q;
   logic [CW-1:0]    cnt;
   logic             bin;
   logic             borrow_q;
   logic             d_bit;
   logic             bout;
   logic             last;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q;
`endif

   assign d_bit = a_sh[0] ^ b_sh[0] ^ bin;
   assign bout  = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & bin) | (b_sh[0] & bin);
   assign last  = (cnt == CW'(1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         diff_q   <= '0;
         cnt      <= '0;
         bin      <= 1'b0;
         borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh   <= bus.A;
                  b_sh   <= bus.B;
                  res_sh <= '0;
                  bin    <= 1'b0;
                  cnt    <= CW'(WIDTH);
               end
            end
            RUN: begin
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               res_sh <= {d_bit, res_sh[WIDTH-1:1]};
               bin    <= bout;
               cnt    <= cnt - CW'(1);
               // Final bit: the MSB stage's borrow-in and borrow-out give signed overflow.
               if (last) begin
                  diff_q   <= {d_bit, res_sh[WIDTH-1:1]};
                  borrow_q <= bout;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q    <= bin ^ bout;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy = (state != IDLE);
      bus.done = (state == DONE);
   end

   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a vector table, hand-written corner sequences,
// and random operations compared against an arithmetic reference model.
module tb_serial_subtractor;
   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   logic clock = 1'b0;
   logic reset = 1'b0;

   serial_subtractor_if #(.WIDTH(W)) bus();

   serial_subtractor #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] d;
      logic         br;
      logic         ov;
      string        name;
   } vec_t;

   vec_t         vecs[8];
   logic [W-1:0] ha[32];
   logic [W-1:0] hb[32];
   int           checks   = 0;
   int           failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic void ref_sub(input int a, input int b, output int d, output int br, output int ov);
      int sa;
      int sb;
      int r;
      d  = (a - b) & MASK;
      br = (a < b) ? 1 : 0;
      sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
      sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
      r  = sa - sb;
      ov = (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
   endfunction

   // Operands are scrambled right after the accept edge; the result must not notice.
   task automatic do_op(input int a, input int b, input int ed, input int eb, input int eo,
                        input string name);
      int lat;
      int busy_n;
      bus.A     = a[W-1:0];
      bus.B     = b[W-1:0];
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.A     = W'($urandom);
      bus.B     = W'($urandom);
      lat       = 0;
      busy_n    = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.busy === 1'b1) busy_n++;
         tick();
         lat++;
      end
      if (bus.busy === 1'b1) busy_n++;
      check({name, " latency"}, lat, W);
      check({name, " diff"}, bus.diff, ed);
      check({name, " borrow"}, bus.borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
      check({name, " ovf"}, bus.ovf, eo);
`else
      if (eo < 0) $display("note: negative ovf expectation ignored");
`endif
      check({name, " busy cycles"}, busy_n, W + 1);
      tick();
      check({name, " done cleared"}, bus.done, 0);
      check({name, " busy cleared"}, bus.busy, 0);
   endtask

   initial begin
      int ed;
      int eb;
      int eo;
      int done_n;
      int first;
      int a;
      int b;

      vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, "5A-3C"};
      vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "00-01"};
      vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "80-01"};
      vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "7F-FF"};
      vecs[4] = '{8'h33, 8'h33, 8'h00, 1'b0, 1'b0, "33-33"};
      vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "00-FF"};
      vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "FF-FF"};
      vecs[7] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1, "01-80"};

      bus.A     = '0;
      bus.B     = '0;
      bus.start = 1'b0;

      #2;
      check("reset busy", bus.busy, 0);
      check("reset done", bus.done, 0);
      check("reset diff", bus.diff, 0);
      check("reset borrow", bus.borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
      check("reset ovf", bus.ovf, 0);
`endif
      tick();
      tick();
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         do_op(int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].d), int'(vecs[i].br),
               int'(vecs[i].ov), vecs[i].name);
      end

      // The result must hold while idle, even with operands moving.
      for (int i = 0; i < 3; i++) begin
         bus.A = W'($urandom);
         bus.B = W'($urandom);
         tick();
      end
      check("hold diff", bus.diff, 8'h81);
      check("hold borrow", bus.borrow, 1);

      // Start pulse mid-run and operand changes after accept are ignored.
      bus.A     = 8'hC3;
      bus.B     = 8'h5A;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.A     = 8'h00;
      bus.B     = 8'hFF;
      tick();
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      done_n    = 0;
      first     = -1;
      for (int c = 4; c <= 24; c++) begin
         tick();
         if (bus.done === 1'b1) begin
            done_n++;
            if (first < 0) first = c;
         end
      end
      check("midstart done count", done_n, 1);
      check("midstart done edge", first, W);
      check("midstart diff", bus.diff, 8'h69);
      check("midstart borrow", bus.borrow, 0);

      // Reset during a run aborts it.
      bus.A     = 8'h5A;
      bus.B     = 8'h3C;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      #3 reset = 1'b0;
      #1;
      check("abort busy", bus.busy, 0);
      check("abort done", bus.done, 0);
      check("abort diff", bus.diff, 0);
      check("abort borrow", bus.borrow, 0);
      done_n = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus.done !== 1'b0) done_n++;
      end
      check("abort no done", done_n, 0);
      reset = 1'b1;
      do_op(8'hFF, 8'hFF, 0, 0, 0, "post-reset FF-FF");

      for (int i = 0; i < 20; i++) begin
         a = int'($urandom_range(0, MASK));
         b = int'($urandom_range(0, MASK));
         ref_sub(a, b, ed, eb, eo);
         do_op(a, b, ed, eb, eo, "random");
      end

      // Start held high: accepts every W+2 edges, each using the operands present at its accept edge.
      bus.start = 1'b1;
      for (int c = 0; c < 32; c++) begin
         ha[c] = W'($urandom);
         hb[c] = W'($urandom);
         bus.A = ha[c];
         bus.B = hb[c];
         if (c == 30) bus.start = 1'b0;
         tick();
         check("b2b done", bus.done, ((c % (W + 2)) == W) ? 1 : 0);
         if ((c % (W + 2)) == W) begin
            ref_sub(int'(ha[c - W]), int'(hb[c - W]), ed, eb, eo);
            check("b2b diff", bus.diff, ed);
            check("b2b borrow", bus.borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
            check("b2b ovf", bus.ovf, eo);
`endif
         end
      end
      bus.start = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
